mole_round_ctrl: RTL and testbench

Game-round controller that sits directly downstream of the LFSR box mapper. It latches the 3-bit random box number (1–4) at the start of each round and exposes it as the lit target for a bounded window. It then judges player hits from the sensor/key front end, counting score and misses until the game ends.

---
 rtl/mole_round_ctrl.sv | 126 ++++++++++++
 tb/tb_mole_round_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round controller: latches the drawn box, times the lit window, judges hits, tracks score/misses.
// Optional SPEEDUP_EN: the lit window shrinks by ON_STEP after every correct hit, floored at ON_MIN.
module mole_round_ctrl #(
  parameter int unsigned ON_CYCLES  = 50_000_000,
  parameter int unsigned GAP_CYCLES = 25_000_000,
  parameter int unsigned MAX_MISSES = 3,
  parameter int unsigned ON_STEP    = 5_000_000,
  parameter int unsigned ON_MIN     = 10_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset_signal,
  input  logic       start,
  input  logic [2:0] lfsr_address,
  input  logic       hit_valid,
  input  logic [2:0] hit_box,
  output logic [2:0] target_box,
  output logic       target_active,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [7:0] score,
  output logic [3:0] misses,
  output logic       game_over
);

  // Width also covers ON_MIN/ON_STEP so the shrink arithmetic never truncates.
  localparam int unsigned SPAN_A = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int unsigned SPAN_B = (ON_MIN > ON_STEP) ? ON_MIN : ON_STEP;
  localparam int unsigned SPAN   = (SPAN_A > SPAN_B) ? SPAN_A : SPAN_B;
  localparam int unsigned CW     = $clog2(SPAN + 1);

  localparam logic [CW-1:0] ON_W     = CW'(ON_CYCLES);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);
  localparam logic [3:0]    MAX_M    = 4'(MAX_MISSES);

  typedef enum logic [2:0] {IDLE, GAP, SHOW, HIT, MISS, OVER} state_t;

  state_t        state, next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] win;
  logic [2:0]    drawn;
  logic          hit_ok;
  logic          new_game;

  assign drawn    = (lfsr_address >= 3'd1 && lfsr_address <= 3'd4) ? lfsr_address : 3'd1;
  assign hit_ok   = hit_valid && (hit_box == target_box);
  assign new_game = start && (state == IDLE || state == OVER);

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (start) next = GAP;
      GAP:     if (cnt == '0) next = SHOW;
      SHOW: begin
        if (hit_ok)           next = HIT;
        else if (cnt == '0)   next = MISS;
      end
      HIT:     next = GAP;
      MISS:    next = (misses == MAX_M) ? OVER : GAP;
      OVER:    if (start) next = GAP;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset_signal) begin
    if (reset_signal) begin
      state         <= IDLE;
      cnt           <= '0;
      target_box    <= '0;
      target_active <= 1'b0;
      hit_pulse     <= 1'b0;
      miss_pulse    <= 1'b0;
      score         <= '0;
      misses        <= '0;
      game_over     <= 1'b0;
    end else begin
      state         <= next;
      target_active <= (next == SHOW);
      hit_pulse     <= (next == HIT);
      miss_pulse    <= (next == MISS);
      game_over     <= (next == OVER);

      // Counter reloads on every state change and counts down to 0 otherwise.
      if (next != state) begin
        case (next)
          GAP:     cnt <= GAP_LOAD;
          SHOW:    cnt <= win - CW'(1);
          default: cnt <= '0;
        endcase
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end

      if (next == GAP || next == OVER)
        target_box <= '0;
      else if (state == GAP && next == SHOW)
        target_box <= drawn;

      if (state == IDLE || new_game) begin
        score  <= '0;
        misses <= '0;
      end else if (state == SHOW && next == HIT) begin
        if (score != 8'hFF) score <= score + 8'd1;
      end else if (state == SHOW && next == MISS) begin
        misses <= misses + 4'd1;
      end
    end
  end

`ifdef SPEEDUP_EN
  localparam logic [CW-1:0] STEP_W = CW'(ON_STEP);
  localparam logic [CW-1:0] MIN_W  = CW'(ON_MIN);
  localparam logic [CW:0]   FLOOR  = {1'b0, MIN_W} + {1'b0, STEP_W};

  always_ff @(posedge CLOCK_50 or posedge reset_signal) begin
    if (reset_signal)
      win <= ON_W;
    else if (new_game)
      win <= ON_W;
    else if (state == HIT)
      win <= ({1'b0, win} >= FLOOR) ? win - STEP_W : MIN_W;
  end
`else
  assign win = ON_W;
`endif

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Directed self-checking bench for mole_round_ctrl (ON=8, GAP=4, MAX_MISSES=3; speedup rounds when SPEEDUP_EN).
module tb_mole_round_ctrl;

  logic       CLOCK_50;
  logic       reset_signal;
  logic       start;
  logic [2:0] lfsr_address;
  logic       hit_valid;
  logic [2:0] hit_box;
  logic [2:0] target_box;
  logic       target_active;
  logic       hit_pulse;
  logic       miss_pulse;
  logic [7:0] score;
  logic [3:0] misses;
  logic       game_over;

  int unsigned tests;
  int unsigned failures;

  mole_round_ctrl #(
    .ON_CYCLES (8),
    .GAP_CYCLES(4),
    .MAX_MISSES(3),
    .ON_STEP   (2),
    .ON_MIN    (4)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset_signal (reset_signal),
    .start        (start),
    .lfsr_address (lfsr_address),
    .hit_valid    (hit_valid),
    .hit_box      (hit_box),
    .target_box   (target_box),
    .target_active(target_active),
    .hit_pulse    (hit_pulse),
    .miss_pulse   (miss_pulse),
    .score        (score),
    .misses       (misses),
    .game_over    (game_over)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".target_box"}, 32'(target_box), 0);
    chk({tag, ".target_active"}, 32'(target_active), 0);
    chk({tag, ".hit_pulse"}, 32'(hit_pulse), 0);
    chk({tag, ".miss_pulse"}, 32'(miss_pulse), 0);
    chk({tag, ".score"}, 32'(score), 0);
    chk({tag, ".misses"}, 32'(misses), 0);
    chk({tag, ".game_over"}, 32'(game_over), 0);
  endtask

  // Called right after GAP entry: runs a full window with no hit and checks the miss.
  task automatic miss_round(input int unsigned exp_misses, input int unsigned win_len);
    repeat (4) tick();
    chk("miss_round.active_rise", 32'(target_active), 1);
    repeat (win_len - 1) tick();
    chk("miss_round.active_last", 32'(target_active), 1);
    chk("miss_round.no_early_miss", 32'(miss_pulse), 0);
    tick();
    chk("miss_round.miss_pulse", 32'(miss_pulse), 1);
    chk("miss_round.active_off", 32'(target_active), 0);
    chk("miss_round.misses", 32'(misses), 32'(exp_misses));
    tick();
    chk("miss_round.pulse_once", 32'(miss_pulse), 0);
  endtask

  // Called right after GAP entry: hits the target on SHOW cycle n, returns right after GAP re-entry.
  task automatic hit_round(input logic [2:0] box, input int unsigned n, input int unsigned exp_score);
    repeat (4) tick();
    chk("hit_round.box", 32'(target_box), 32'(box));
    repeat (n - 1) tick();
    chk("hit_round.still_active", 32'(target_active), 1);
    hit_valid = 1'b1;
    hit_box   = box;
    tick();
    hit_valid = 1'b0;
    chk("hit_round.hit_pulse", 32'(hit_pulse), 1);
    chk("hit_round.no_miss", 32'(miss_pulse), 0);
    chk("hit_round.score", 32'(score), 32'(exp_score));
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests        = 0;
    failures     = 0;
    reset_signal = 1'b0;
    start        = 1'b0;
    lfsr_address = 3'd3;
    hit_valid    = 1'b0;
    hit_box      = 3'd0;

    #2 reset_signal = 1'b1;
    #1 chk_all_zero("reset_async");
    tick();
    tick();
    reset_signal = 1'b0;
    tick();
    chk_all_zero("idle_after_reset");

    // Start, draw box 3, hit on the 3rd SHOW cycle.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("gap.box_zero", 32'(target_box), 0);
    repeat (3) tick();
    chk("gap.active_low_last", 32'(target_active), 0);
    tick();
    chk("show.active", 32'(target_active), 1);
    chk("show.box", 32'(target_box), 3);
    tick();
    tick();
    hit_valid = 1'b1;
    hit_box   = 3'd3;
    tick();
    hit_valid = 1'b0;
    chk("hit3.hit_pulse", 32'(hit_pulse), 1);
    chk("hit3.active_off", 32'(target_active), 0);
    chk("hit3.score", 32'(score), 1);
    tick();
    chk("hit3.pulse_once", 32'(hit_pulse), 0);
    chk("hit3.gap_box", 32'(target_box), 0);
    chk("hit3.score_hold", 32'(score), 1);

    // Three unanswered windows end the game.
    miss_round(1, 8);
    miss_round(2, 8);
    repeat (4) tick();
    repeat (8) tick();
    chk("miss3.misses", 32'(misses), 3);
    chk("miss3.pulse", 32'(miss_pulse), 1);
    tick();
    chk("over.game_over", 32'(game_over), 1);
    chk("over.box", 32'(target_box), 0);
    chk("over.misses", 32'(misses), 3);
    chk("over.score_held", 32'(score), 1);
    hit_valid = 1'b1;
    hit_box   = 3'd3;
    repeat (3) tick();
    hit_valid = 1'b0;
    chk("over.stays", 32'(game_over), 1);
    chk("over.no_hit", 32'(hit_pulse), 0);
    chk("over.score_still", 32'(score), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart.game_over", 32'(game_over), 0);
    chk("restart.score", 32'(score), 0);
    chk("restart.misses", 32'(misses), 0);

    // Wrong box is ignored and the window still expires on time.
    lfsr_address = 3'd2;
    repeat (4) tick();
    chk("wrong.box", 32'(target_box), 2);
    hit_valid = 1'b1;
    hit_box   = 3'd4;
    repeat (7) tick();
    chk("wrong.still_active", 32'(target_active), 1);
    chk("wrong.no_hit", 32'(hit_pulse), 0);
    hit_valid = 1'b0;
    tick();
    chk("wrong.miss_pulse", 32'(miss_pulse), 1);
    chk("wrong.misses", 32'(misses), 1);
    chk("wrong.score", 32'(score), 0);
    tick();

    // Correct hit on the final window cycle beats expiry.
    hit_round(3'd2, 8, 1);
    chk("final.misses", 32'(misses), 1);

    // Out-of-range draw maps to box 1; reset mid-SHOW clears everything.
    lfsr_address = 3'd0;
    repeat (4) tick();
    chk("invalid.box", 32'(target_box), 1);
    chk("invalid.active", 32'(target_active), 1);
    tick();
    tick();
    #2 reset_signal = 1'b1;
    #1 chk_all_zero("reset_mid_show");
    tick();
    tick();
    chk("reset_hold.no_miss", 32'(miss_pulse), 0);
    chk("reset_hold.no_hit", 32'(hit_pulse), 0);
    reset_signal = 1'b0;
    tick();
    chk_all_zero("idle_after_mid_reset");

    // Score saturates at 255 over 256 hits.
    lfsr_address = 3'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      hit_round(3'd4, 1, (i < 255) ? 32'(i + 1) : 32'd255);
    end
    chk("sat.score", 32'(score), 255);
    chk("sat.misses", 32'(misses), 0);

`ifdef SPEEDUP_EN
    // Window shrinks 8 -> 6 -> 4 -> 4; the last one is measured by expiry.
    #2 reset_signal = 1'b1;
    tick();
    reset_signal = 1'b0;
    lfsr_address = 3'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    hit_round(3'd2, 8, 1);
    hit_round(3'd2, 6, 2);
    hit_round(3'd2, 4, 3);
    miss_round(1, 4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
